// File: rtl/lbp_host_mem.sv
// Memory-side responder for the LBP engine: holds the loaded grayscale image,
// serves 1-cycle gray reads, captures interior LBP result writes and exposes them for read-back.
module lbp_host_mem #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [DW-1:0]   load_data,
  output logic            load_ready,
  output logic            gray_ready,
  input  logic            gray_req,
  input  logic [AW-1:0]   gray_addr,
  output logic [DW-1:0]   gray_data,
  input  logic            lbp_valid,
  input  logic [AW-1:0]   lbp_addr,
  input  logic [DW-1:0]   lbp_data,
  input  logic            finish,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            done,
  output logic            err_border,
  output logic [AW:0]     wr_count
);

  localparam int LW   = $clog2(IMG_W);
  localparam int RW   = AW - LW;
  localparam int NPIX = IMG_W * IMG_H;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW-1:0] CNT_ONE   = AW'(1);
  localparam logic [AW:0]   WR_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   WR_MAX    = {(AW+1){1'b1}};
  localparam logic [RW-1:0] ROW_FIRST = {RW{1'b0}};
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [LW-1:0] COL_FIRST = {LW{1'b0}};
  localparam logic [LW-1:0] COL_LAST  = LW'(IMG_W - 1);
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_r, state_nxt;
  logic [AW-1:0] cnt_r;

  logic          load_acc_s;
  logic          gray_rd_s;
  logic          lbp_wr_s;
  logic          border_hit_s;
  logic          res_we_s;
  logic [AW-1:0] res_waddr_s;
  logic [DW-1:0] res_wdata_s;

  logic [DW-1:0] gray_mem [NPIX];
  logic [DW-1:0] res_mem  [NPIX];

  // Only pixels with a full 3x3 neighbourhood may receive an LBP result.
  function automatic logic is_interior(input logic [AW-1:0] addr);
    logic [RW-1:0] row;
    logic [LW-1:0] col;
    row = addr[AW-1:LW];
    col = addr[LW-1:0];
    return (row != ROW_FIRST) && (row != ROW_LAST) &&
           (col != COL_FIRST) && (col != COL_LAST);
  endfunction

  // Next-state and per-cycle access decode.
  always_comb begin
    state_nxt    = state_r;
    load_acc_s   = 1'b0;
    gray_rd_s    = 1'b0;
    lbp_wr_s     = 1'b0;
    border_hit_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (load_valid) begin
          load_acc_s = 1'b1;
          if (cnt_r == LAST_ADDR) begin
            state_nxt = ST_SERVE;
          end else begin
            state_nxt = ST_LOAD;
          end
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_SERVE: begin
        gray_rd_s    = gray_req;
        lbp_wr_s     = lbp_valid & is_interior(lbp_addr);
        border_hit_s = lbp_valid & ~is_interior(lbp_addr);
        if (finish) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SERVE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

  // Result memory has a single write port: load-time clearing or an accepted LBP write.
  always_comb begin
    res_we_s    = load_acc_s | lbp_wr_s;
    res_waddr_s = lbp_addr;
    res_wdata_s = lbp_data;
    if (load_acc_s) begin
      res_waddr_s = cnt_r;
      res_wdata_s = DATA_ZERO;
    end else begin
      res_waddr_s = lbp_addr;
      res_wdata_s = lbp_data;
    end
  end

  // Memory arrays, intentionally not reset.
  always_ff @(posedge clk) begin
    if (load_acc_s) begin
      gray_mem[cnt_r] <= load_data;
    end
    if (res_we_s) begin
      res_mem[res_waddr_s] <= res_wdata_s;
    end
  end

  // Control state, counters, flags and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_LOAD;
      cnt_r      <= {AW{1'b0}};
      load_ready <= 1'b1;
      gray_ready <= 1'b0;
      done       <= 1'b0;
      gray_data  <= DATA_ZERO;
      rd_data    <= DATA_ZERO;
      err_border <= 1'b0;
      wr_count   <= {(AW+1){1'b0}};
    end else begin
      state_r    <= state_nxt;
      load_ready <= (state_nxt == ST_LOAD);
      gray_ready <= (state_nxt == ST_SERVE);
      done       <= (state_nxt == ST_DONE);
      rd_data    <= res_mem[rd_addr];
      if (load_acc_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (gray_rd_s) begin
        gray_data <= gray_mem[gray_addr];
      end
      if (border_hit_s) begin
        err_border <= 1'b1;
      end
      if (lbp_wr_s && (wr_count != WR_MAX)) begin
        wr_count <= wr_count + WR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed plus randomized bench for lbp_host_mem, checked against an
// array-based model of the image/result memories and the host-side flags.
module tb_lbp_host_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic [13:0] rd_addr;
  logic [7:0]  rd_data;
  logic        done;
  logic        err_border;
  logic [14:0] wr_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] gray_m [16384];
  logic [7:0] res_m  [16384];
  logic [7:0] exp_gray;
  int         exp_cnt;
  bit         exp_err;
  bit         exp_done;
  int         last_wr;

  lbp_host_mem dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .rd_addr(rd_addr), .rd_data(rd_data),
    .done(done), .err_border(err_border), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit interior(input int a);
    int r, c;
    r = a / 128;
    c = a % 128;
    return (r > 0) && (r < 127) && (c > 0) && (c < 127);
  endfunction

  task automatic idle_inputs();
    load_valid = 1'b0; load_data = 8'd0;
    gray_req = 1'b0;   gray_addr = 14'd0;
    lbp_valid = 1'b0;  lbp_addr = 14'd0; lbp_data = 8'd0;
    finish = 1'b0;     rd_addr = 14'd0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    chk({tag, "_gray_ready"}, 32'(gray_ready), 32'd0);
    chk({tag, "_gray_data"},  32'(gray_data),  32'd0);
    chk({tag, "_rd_data"},    32'(rd_data),    32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_err_border"}, 32'(err_border), 32'd0);
    chk({tag, "_wr_count"},   32'(wr_count),   32'd0);
  endtask

  // Streams nbeats pixels; gray/lbp traffic during load must be ignored.
  task automatic load_image(input int nbeats, input bit ramp);
    for (int i = 0; i < nbeats; i++) begin
      if (i % 2048 == 1000) begin
        load_valid = 1'b0;
        tick();
      end
      load_valid = 1'b1;
      load_data  = ramp ? 8'(i) : 8'($urandom);
      gray_req   = 1'b1;
      gray_addr  = 14'($urandom);
      lbp_valid  = 1'($urandom_range(0, 1));
      lbp_addr   = 14'd129;
      lbp_data   = 8'hEE;
      gray_m[i]  = load_data;
      res_m[i]   = 8'd0;
      if ((i % 1024 == 0) || (i == 16383)) begin
        chk("load_ready_during_load", 32'(load_ready), 32'd1);
        chk("gray_ready_during_load", 32'(gray_ready), 32'd0);
        chk("gray_data_during_load",  32'(gray_data),  32'd0);
        chk("wr_count_during_load",   32'(wr_count),   32'd0);
      end
      tick();
    end
    idle_inputs();
    if (nbeats == 16384) begin
      chk("load_ready_after_load", 32'(load_ready), 32'd0);
      chk("gray_ready_after_load", 32'(gray_ready), 32'd1);
      exp_gray = 8'd0;
      exp_cnt  = 0;
      exp_err  = 1'b0;
      exp_done = 1'b0;
    end
  endtask

  // One post-load cycle: drive, update the model, clock, compare every output.
  task automatic serve_cycle(input bit greq, input int gaddr, input bit lv, input int laddr,
                             input int ldata, input bit fin, input int raddr);
    logic [7:0] exp_rd;
    gray_req  = greq;  gray_addr = 14'(gaddr);
    lbp_valid = lv;    lbp_addr  = 14'(laddr); lbp_data = 8'(ldata);
    finish    = fin;   rd_addr   = 14'(raddr);
    load_valid = 1'($urandom_range(0, 1));
    load_data  = 8'($urandom);
    exp_rd = res_m[raddr];
    if (!exp_done) begin
      if (greq) exp_gray = gray_m[gaddr];
      if (lv) begin
        if (interior(laddr)) begin
          res_m[laddr] = 8'(ldata);
          last_wr = laddr;
          if (exp_cnt < 32767) exp_cnt++;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (fin) exp_done = 1'b1;
    end
    tick();
    chk("gray_data",  32'(gray_data),  32'(exp_gray));
    chk("rd_data",    32'(rd_data),    32'(exp_rd));
    chk("wr_count",   32'(wr_count),   32'(exp_cnt));
    chk("err_border", 32'(err_border), 32'(exp_err));
    chk("done",       32'(done),       32'(exp_done));
    chk("gray_ready", 32'(gray_ready), 32'(!exp_done));
    chk("load_ready", 32'(load_ready), 32'd0);
    idle_inputs();
  endtask

  initial begin
    int ga, la, ra;
    reset = 1'b0;
    idle_inputs();
    last_wr = 129;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_outputs("por");
    reset = 1'b1;

    load_image(16384, 1'b1);

    serve_cycle(1'b1, 129, 1'b0, 0, 0, 1'b0, 0);
    chk("read_129", 32'(gray_data), 32'd129);
    serve_cycle(1'b1, 0,   1'b0, 0, 0, 1'b0, 0);
    chk("read_0", 32'(gray_data), 32'd0);
    serve_cycle(1'b1, 1,   1'b0, 0, 0, 1'b0, 0);
    chk("read_1", 32'(gray_data), 32'd1);
    serve_cycle(1'b1, 128, 1'b0, 0, 0, 1'b0, 0);
    chk("read_128", 32'(gray_data), 32'd128);
    serve_cycle(1'b0, 5,   1'b0, 0, 0, 1'b0, 0);
    chk("read_hold", 32'(gray_data), 32'd128);

    serve_cycle(1'b0, 0, 1'b1, 129, 8'hA5, 1'b0, 0);
    serve_cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 129);
    chk("interior_rd", 32'(rd_data), 32'hA5);
    chk("interior_cnt", 32'(wr_count), 32'd1);
    chk("interior_err", 32'(err_border), 32'd0);

    serve_cycle(1'b0, 0, 1'b1, 0,     8'hFF, 1'b0, 0);
    serve_cycle(1'b0, 0, 1'b1, 127,   8'hFF, 1'b0, 0);
    serve_cycle(1'b0, 0, 1'b1, 16256, 8'hFF, 1'b0, 0);
    serve_cycle(1'b0, 0, 1'b1, 255,   8'hFF, 1'b0, 0);
    chk("border_err", 32'(err_border), 32'd1);
    chk("border_cnt", 32'(wr_count), 32'd1);
    serve_cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    chk("border_rd_0", 32'(rd_data), 32'd0);
    serve_cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 127);
    chk("border_rd_127", 32'(rd_data), 32'd0);
    serve_cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 16256);
    chk("border_rd_16256", 32'(rd_data), 32'd0);
    serve_cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 255);
    chk("border_rd_255", 32'(rd_data), 32'd0);

    for (int k = 0; k < 400; k++) begin
      ga = int'($urandom_range(0, 16383));
      la = int'($urandom_range(0, 16383));
      if (la == 130 || la == 16254) la = 131;
      ra = ($urandom_range(0, 1) == 1) ? last_wr : int'($urandom_range(0, 16383));
      serve_cycle(1'($urandom_range(0, 1)), ga, ($urandom_range(0, 2) == 0), la,
                  int'($urandom_range(0, 255)), 1'b0, ra);
    end

    serve_cycle(1'b0, 0, 1'b1, 16254, 8'h3C, 1'b1, 0);
    chk("finish_done", 32'(done), 32'd1);
    chk("finish_gray_ready", 32'(gray_ready), 32'd0);
    serve_cycle(1'b1, 77, 1'b1, 130, 8'h77, 1'b0, 16254);
    chk("finish_same_cycle_write", 32'(rd_data), 32'h3C);
    serve_cycle(1'b1, 300, 1'b0, 0, 0, 1'b0, 130);
    chk("after_done_write_ignored", 32'(rd_data), 32'd0);

    reset = 1'b0;
    #1;
    chk_reset_outputs("reset_after_done");
    tick();
    reset = 1'b1;

    load_image(5000, 1'b0);
    load_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk_reset_outputs("reset_mid_load");
    tick();
    chk_reset_outputs("reset_held");
    idle_inputs();
    reset = 1'b1;

    load_image(16384, 1'b0);
    serve_cycle(1'b1, 4999, 1'b0, 0, 0, 1'b0, 129);
    chk("reload_rd_129_zeroed", 32'(rd_data), 32'd0);
    serve_cycle(1'b1, 5000, 1'b0, 0, 0, 1'b0, 16254);
    chk("reload_rd_16254_zeroed", 32'(rd_data), 32'd0);
    for (int k = 0; k < 40; k++) begin
      serve_cycle(1'b1, int'($urandom_range(0, 16383)), 1'b0, 0, 0, 1'b0,
                  int'($urandom_range(0, 16383)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
